usb_data_buffer: RTL and testbench
==================================

Name: usb_data_buffer

Overview:
- Byte-wide circular FIFO holding one USB data packet payload.
- Sits between the AHB slave (word/halfword/byte side) and the USB RX/TX packet engines (byte side).
- Consumes the AHB slave's get_rx_data, store_tx_data, tx_data and clear_data_buffer.
- Produces rx_data and buffer_occupancy for the AHB slave's registers.

Parameters:
- DEPTH, 64: capacity in bytes. Must be a power of 2 and at most 128.
- PTR_W, $clog2(DEPTH): read/write pointer width. Derived from DEPTH; not overridden.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- clear_data_buffer  in  1  flush; empties the FIFO
- get_rx_data  in  2  AHB pop size: 00 none, 01 1 byte, 10 2 bytes, 11 4 bytes
- store_tx_data  in  2  AHB push size, same encoding as get_rx_data
- tx_data  in  32  AHB push data; byte 0 = bits [7:0], pushed first
- rx_data  out  32  head 4 bytes, little-endian (head byte in [7:0])
- buffer_occupancy  out  8  bytes currently stored, 0..DEPTH
- store_rx_packet_data  in  1  USB RX pushes one byte
- rx_packet_data  in  8  USB RX byte
- get_tx_packet_data  in  1  USB TX pops one byte
- tx_packet_data  out  8  head byte for USB TX

Behaviour:
- Reset: pointers 0, occupancy 0. rx_data, tx_packet_data and buffer_occupancy all read 0.
- Storage: DEPTH x 8 array, not reset. Pointers are PTR_W bits and wrap modulo DEPTH.
- Occupancy is a registered count, range 0..DEPTH, zero-extended to 8 bits.
- Read paths (combinational from the registered head pointer, zero latency):
  - rx_data byte k = mem[rd_ptr+k] when k < occupancy, else 0.
  - tx_packet_data = mem[rd_ptr] when occupancy > 0, else 0.
  - The AHB slave samples rx_data in the same cycle it asserts get_rx_data.
- Push/pop sizes: N_push = decode(store_tx_data), or 1 for a USB RX push. N_pop = decode(get_rx_data), or 1 for a USB TX pop.
- Same-side conflicts:
  - Both pushes in one cycle: the AHB push wins and the USB RX byte is dropped.
  - Both pops in one cycle: the AHB pop wins.
- Limits use the occupancy at the start of the cycle (no same-cycle bypass):
  - accepted pops = min(N_pop, occ)
  - accepted pushes = min(N_push, DEPTH - occ)
  - Bytes beyond either limit are ignored: excess pop bytes are not consumed, excess push bytes are discarded, highest bytes first.
- A push and a pop may occur in the same cycle. The next occupancy is occ + accepted pushes - accepted pops.
- Push at occ = DEPTH-1 with N_push = 4: one byte accepted.
- clear_data_buffer has priority over all pushes and pops in that cycle. Next cycle: rd_ptr = wr_ptr = 0 and occ = 0.
- Reset asserted mid-transfer: state returns to reset values immediately (asynchronous); the partial packet is lost.
- Pointer wrap is transparent: a 4-byte pop that straddles DEPTH-1 to 0 returns the bytes in FIFO order.

Optional Feature:
- Macro: USB_DATA_BUFFER_ERROR_EN.
- Defined: adds output buffer_error (1 bit, registered, reset 0). It pulses high for exactly one cycle after any cycle in which any of these occurred:
  - a push was truncated
  - a pop was truncated
  - a USB RX byte was dropped because of a same-cycle AHB push
  - a USB TX pop was dropped because of a same-cycle AHB pop
  - Never asserted in the cycle after clear_data_buffer.
- Undefined: the port is absent and the same events are silently truncated as described.

Test Plan:
- Reset, then idle -> buffer_occupancy = 0, rx_data = 0, tx_packet_data = 0.
- USB RX pushes 0x11, 0x22, 0x33, 0x44, 0x55 -> occupancy 5, rx_data = 0x44332211. Then get_rx_data = 11 -> occupancy 1, rx_data = 0x00000055.
- AHB store_tx_data = 11 with tx_data = 0xDDCCBBAA, then USB TX pops 4 times -> tx_packet_data sequence AA, BB, CC, DD; occupancy 0.
- Fill to 63 bytes, then store_tx_data = 11 with tx_data = 0x04030201 -> occupancy 64, only 0x01 stored. buffer_error pulses when USB_DATA_BUFFER_ERROR_EN is defined.
- Advance pointers to 62, push 4 bytes 0xA0..0xA3, then get_rx_data = 11 -> rx_data = 0xA3A2A1A0 across the wrap.
- With occupancy 10, assert clear_data_buffer together with a store_tx_data = 11 push -> next cycle occupancy 0, rx_data = 0, and no buffer_error pulse.

Source files
------------

// File: rtl/usb_data_buffer_if.sv
// Buffer-side bundle: AHB word/halfword/byte push/pop and USB RX/TX byte push/pop.
// buffer_error exists only when USB_DATA_BUFFER_ERROR_EN is defined.
interface usb_data_buffer_if;
    logic        clear_data_buffer;
    logic [1:0]  get_rx_data;
    logic [1:0]  store_tx_data;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic [7:0]  buffer_occupancy;
    logic        store_rx_packet_data;
    logic [7:0]  rx_packet_data;
    logic        get_tx_packet_data;
    logic [7:0]  tx_packet_data;
`ifdef USB_DATA_BUFFER_ERROR_EN
    logic        buffer_error;

    modport slave (
        input  clear_data_buffer, get_rx_data, store_tx_data, tx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, buffer_occupancy, tx_packet_data, buffer_error
    );
    modport master (
        output clear_data_buffer, get_rx_data, store_tx_data, tx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, buffer_occupancy, tx_packet_data, buffer_error
    );
`else
    modport slave (
        input  clear_data_buffer, get_rx_data, store_tx_data, tx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, buffer_occupancy, tx_packet_data
    );
    modport master (
        output clear_data_buffer, get_rx_data, store_tx_data, tx_data,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, buffer_occupancy, tx_packet_data
    );
`endif
endinterface

// File: rtl/usb_data_buffer.sv
// Byte-wide circular packet FIFO between the AHB slave and the USB RX/TX engines.
// Latency: head bytes are combinational from registered state; pushes visible next cycle.
// Backpressure: none; pops beyond occupancy and pushes beyond free space are truncated.
// Optional USB_DATA_BUFFER_ERROR_EN adds a registered one-cycle buffer_error pulse.
module usb_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    usb_data_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [7:0]       occ;

    logic       ahb_push;
    logic       ahb_pop;
    logic [2:0] n_push;
    logic [2:0] n_pop;
    logic [2:0] acc_push;
    logic [2:0] acc_pop;
    logic [7:0] space;
    logic [7:0] push_byte [4];

    function automatic logic [2:0] decode_size(input logic [1:0] sz);
        case (sz)
            2'b01:   decode_size = 3'd1;
            2'b10:   decode_size = 3'd2;
            2'b11:   decode_size = 3'd4;
            default: decode_size = 3'd0;
        endcase
    endfunction

    // AHB side wins a same-direction conflict; the USB request is simply ignored.
    always_comb begin
        ahb_push = (bus.store_tx_data != 2'b00);
        ahb_pop  = (bus.get_rx_data != 2'b00);
        n_push   = ahb_push ? decode_size(bus.store_tx_data) : {2'b00, bus.store_rx_packet_data};
        n_pop    = ahb_pop  ? decode_size(bus.get_rx_data)   : {2'b00, bus.get_tx_packet_data};
        space    = DEPTH_B - occ;
        acc_push = ({5'b0, n_push} > space) ? space[2:0] : n_push;
        acc_pop  = ({5'b0, n_pop} > occ) ? occ[2:0] : n_pop;
        for (int k = 0; k < 4; k++) begin
            push_byte[k] = ahb_push ? bus.tx_data[8*k +: 8] : bus.rx_packet_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (bus.clear_data_buffer) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(acc_pop);
            wr_ptr <= wr_ptr + PTR_W'(acc_push);
            occ    <= occ + {5'b0, acc_push} - {5'b0, acc_pop};
        end
    end

    // Payload storage carries no reset; occupancy masks stale contents.
    always_ff @(posedge clk) begin
        if (!bus.clear_data_buffer) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < acc_push) begin
                    mem[wr_ptr + PTR_W'(k)] <= push_byte[k];
                end
            end
        end
    end

    always_comb begin
        bus.rx_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (8'(k) < occ) begin
                bus.rx_data[8*k +: 8] = mem[rd_ptr + PTR_W'(k)];
            end
        end
        bus.tx_packet_data   = (occ != 8'd0) ? mem[rd_ptr] : 8'h00;
        bus.buffer_occupancy = occ;
    end

`ifdef USB_DATA_BUFFER_ERROR_EN
    logic err_evt;
    logic err_q;

    always_comb begin
        err_evt = (acc_push != n_push) || (acc_pop != n_pop)
               || (ahb_push && bus.store_rx_packet_data)
               || (ahb_pop && bus.get_tx_packet_data);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_evt && !bus.clear_data_buffer;
        end
    end

    assign bus.buffer_error = err_q;
`endif
endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed table-driven bench for usb_data_buffer (DEPTH = 64) plus wrap/full/reset sequences.
module tb_usb_data_buffer;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    usb_data_buffer_if bus();

    usb_data_buffer #(.DEPTH(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [1:0]  get_rx;
        logic [1:0]  store_tx;
        logic [31:0] txd;
        logic        srx;
        logic [7:0]  rxb;
        logic        gtx;
        logic [7:0]  occ;
        logic [31:0] rxd;
        logic [7:0]  txp;
        logic        err;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [7:0] occ, input logic [31:0] rxd,
                             input logic [7:0] txp, input logic err);
        chk({name, " occ"}, {24'h0, bus.buffer_occupancy}, {24'h0, occ});
        chk({name, " rx_data"}, bus.rx_data, rxd);
        chk({name, " tx_pkt"}, {24'h0, bus.tx_packet_data}, {24'h0, txp});
`ifdef USB_DATA_BUFFER_ERROR_EN
        chk({name, " err"}, {31'h0, bus.buffer_error}, {31'h0, err});
`else
        if (err === 1'bx) $display("unexpected x expectation in %s", name);
`endif
    endtask

    task automatic idle();
        bus.clear_data_buffer    = 1'b0;
        bus.get_rx_data          = 2'b00;
        bus.store_tx_data        = 2'b00;
        bus.tx_data              = 32'h0;
        bus.store_rx_packet_data = 1'b0;
        bus.rx_packet_data       = 8'h0;
        bus.get_tx_packet_data   = 1'b0;
    endtask

    // Drive one cycle of requests, return #1 after the edge with inputs idle.
    task automatic cyc(input logic clr, input logic [1:0] g, input logic [1:0] s,
                       input logic [31:0] d, input logic srx, input logic [7:0] rb,
                       input logic gtx);
        bus.clear_data_buffer    = clr;
        bus.get_rx_data          = g;
        bus.store_tx_data        = s;
        bus.tx_data              = d;
        bus.store_rx_packet_data = srx;
        bus.rx_packet_data       = rb;
        bus.get_tx_packet_data   = gtx;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        //           clr get st  tx_data       srx rxb    gtx  occ    rx_data       txp    err
        tbl[0]  = '{0, 0, 0, 32'h0,         0, 8'h00, 0, 8'd0,  32'h0,        8'h00, 0};
        tbl[1]  = '{0, 0, 0, 32'h0,         1, 8'h11, 0, 8'd1,  32'h00000011, 8'h11, 0};
        tbl[2]  = '{0, 0, 0, 32'h0,         1, 8'h22, 0, 8'd2,  32'h00002211, 8'h11, 0};
        tbl[3]  = '{0, 0, 0, 32'h0,         1, 8'h33, 0, 8'd3,  32'h00332211, 8'h11, 0};
        tbl[4]  = '{0, 0, 0, 32'h0,         1, 8'h44, 0, 8'd4,  32'h44332211, 8'h11, 0};
        tbl[5]  = '{0, 0, 0, 32'h0,         1, 8'h55, 0, 8'd5,  32'h44332211, 8'h11, 0};
        tbl[6]  = '{0, 3, 0, 32'h0,         0, 8'h00, 0, 8'd1,  32'h00000055, 8'h55, 0};
        tbl[7]  = '{0, 1, 0, 32'h0,         0, 8'h00, 0, 8'd0,  32'h0,        8'h00, 0};
        tbl[8]  = '{0, 0, 3, 32'hDDCCBBAA,  0, 8'h00, 0, 8'd4,  32'hDDCCBBAA, 8'hAA, 0};
        tbl[9]  = '{0, 0, 0, 32'h0,         0, 8'h00, 1, 8'd3,  32'h00DDCCBB, 8'hBB, 0};
        tbl[10] = '{0, 0, 0, 32'h0,         0, 8'h00, 1, 8'd2,  32'h0000DDCC, 8'hCC, 0};
        tbl[11] = '{0, 0, 0, 32'h0,         0, 8'h00, 1, 8'd1,  32'h000000DD, 8'hDD, 0};
        tbl[12] = '{0, 0, 0, 32'h0,         0, 8'h00, 1, 8'd0,  32'h0,        8'h00, 0};
        tbl[13] = '{0, 2, 0, 32'h0,         0, 8'h00, 0, 8'd0,  32'h0,        8'h00, 1};
        tbl[14] = '{0, 0, 1, 32'h000000EE,  1, 8'h77, 0, 8'd1,  32'h000000EE, 8'hEE, 1};
        tbl[15] = '{0, 1, 0, 32'h0,         0, 8'h00, 1, 8'd0,  32'h0,        8'h00, 1};
        tbl[16] = '{0, 0, 2, 32'h00003412,  0, 8'h00, 1, 8'd2,  32'h00003412, 8'h12, 1};
        tbl[17] = '{0, 1, 0, 32'h0,         1, 8'h56, 0, 8'd2,  32'h00005634, 8'h34, 0};
        tbl[18] = '{0, 0, 0, 32'h0,         0, 8'h00, 0, 8'd2,  32'h00005634, 8'h34, 0};
        tbl[19] = '{0, 0, 3, 32'h03020100,  0, 8'h00, 0, 8'd6,  32'h01005634, 8'h34, 0};
        tbl[20] = '{0, 0, 3, 32'h07060504,  0, 8'h00, 0, 8'd10, 32'h01005634, 8'h34, 0};
        tbl[21] = '{1, 3, 3, 32'hFFFFFFFF,  1, 8'h99, 1, 8'd0,  32'h0,        8'h00, 0};

        idle();
        #12;
        chk_state("reset", 8'd0, 32'h0, 8'h00, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].clr, tbl[i].get_rx, tbl[i].store_tx, tbl[i].txd,
                tbl[i].srx, tbl[i].rxb, tbl[i].gtx);
            chk_state($sformatf("vec%0d", i), tbl[i].occ, tbl[i].rxd, tbl[i].txp, tbl[i].err);
        end

        // Fill to DEPTH-1 with byte value = fill index, then overflow by a 4-byte push.
        for (int i = 0; i < 15; i++) begin
            cyc(0, 2'b00, 2'b11, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 0, 8'h00, 0);
        end
        for (int i = 60; i < 63; i++) cyc(0, 2'b00, 2'b00, 32'h0, 1, 8'(i), 0);
        chk_state("fill63", 8'd63, 32'h03020100, 8'h00, 1'b0);
        cyc(0, 2'b00, 2'b11, 32'h04030201, 0, 8'h00, 0);
        chk_state("full_push", 8'd64, 32'h03020100, 8'h00, 1'b1);
        cyc(0, 2'b00, 2'b00, 32'h0, 1, 8'hEE, 0);
        chk_state("push_at_full", 8'd64, 32'h03020100, 8'h00, 1'b1);
        cyc(0, 2'b00, 2'b00, 32'h0, 0, 8'h00, 0);
        chk_state("err_one_cycle", 8'd64, 32'h03020100, 8'h00, 1'b0);
        for (int i = 0; i < 15; i++) cyc(0, 2'b11, 2'b00, 32'h0, 0, 8'h00, 0);
        chk_state("drain_tail", 8'd4, 32'h013E3D3C, 8'h3C, 1'b0);
        cyc(0, 2'b11, 2'b00, 32'h0, 0, 8'h00, 0);
        chk_state("drained", 8'd0, 32'h0, 8'h00, 1'b0);

        // Walk both pointers to 62, then a 4-byte push/pop straddles the wrap.
        for (int i = 0; i < 15; i++) begin
            cyc(0, 2'b00, 2'b11, 32'h5A5A5A5A, 0, 8'h00, 0);
            cyc(0, 2'b11, 2'b00, 32'h0, 0, 8'h00, 0);
        end
        cyc(0, 2'b00, 2'b10, 32'h00005A5A, 0, 8'h00, 0);
        cyc(0, 2'b10, 2'b00, 32'h0, 0, 8'h00, 0);
        chk_state("at62", 8'd0, 32'h0, 8'h00, 1'b0);
        cyc(0, 2'b00, 2'b11, 32'hA3A2A1A0, 0, 8'h00, 0);
        chk_state("wrap_push", 8'd4, 32'hA3A2A1A0, 8'hA0, 1'b0);
        cyc(0, 2'b11, 2'b00, 32'h0, 0, 8'h00, 0);
        chk_state("wrap_pop", 8'd0, 32'h0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a partial packet.
        cyc(0, 2'b00, 2'b00, 32'h0, 1, 8'h42, 0);
        cyc(0, 2'b00, 2'b00, 32'h0, 1, 8'h43, 0);
        chk_state("pre_reset", 8'd2, 32'h00004342, 8'h42, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk_state("async_reset", 8'd0, 32'h0, 8'h00, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
